// File: rtl/strait_pkg.sv
// rtl/strait_pkg.sv - shared state type and default sizing for the fault analyzer
package strait_pkg;

  // Controller phases: gather reports, classify, stream to eNVM, pulse done
  typedef enum logic [2:0] {
    FA_IDLE,
    FA_COLLECT,
    FA_ANALYZE,
    FA_DUMP,
    FA_DONE
  } fa_state_t;

  localparam int FA_SYSTOLIC_SIZE  = 8;
  localparam int FA_ROW_THRESHOLD  = 2;
  localparam int FA_COL_THRESHOLD  = 2;

endpackage

// File: rtl/fault_popcount.sv
// rtl/fault_popcount.sv - population count of a WIDTH-bit vector
module fault_popcount #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     bits,
  output logic [CNT_WIDTH-1:0] count
);

  // Sum of set bits; CNT_WIDTH is wide enough for an all-ones vector
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_WIDTH'(bits[i]);
    end
  end

endmodule

// File: rtl/fault_analyzer.sv
// rtl/fault_analyzer.sv - sticky PE fault map, row/column classification and eNVM row streaming (optional FAULT_ANALYZER_MASK_EN)
module fault_analyzer
  import strait_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = FA_SYSTOLIC_SIZE,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
  parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE + 1),
  parameter int ROW_THRESHOLD = FA_ROW_THRESHOLD,
  parameter int COL_THRESHOLD = FA_COL_THRESHOLD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pe_fault_valid,
  input  logic [ADDR_WIDTH-1:0]    pe_fault_row,
  input  logic [SYSTOLIC_SIZE-1:0] pe_fault_vec,
  input  logic                     test_done,
  output logic                     busy,
  output logic                     done,
  output logic                     detection_en,
  output logic [ADDR_WIDTH-1:0]    counter,
  output logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
  output logic                     row_fault_detection,
  output logic                     column_fault_detection
);

  localparam int N     = SYSTOLIC_SIZE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  fa_state_t      state;
  logic [N-1:0]   map      [N];
  logic [N-1:0]   col_bits [N];
  logic [N-1:0]   row_flag;
  logic [N-1:0]   col_flag;
  logic [N-1:0]   row_flag_nx;
  logic [N-1:0]   col_flag_nx;

  logic [IDX_W-1:0] wr_idx;
  logic             wr_ok;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             last_row;

  logic [IDX_W-1:0] sel_idx;
  logic [N-1:0]     sel_row_flags;
  logic [N-1:0]     sel_col_flags;
  logic [N-1:0]     sel_single;
  logic             sel_row;
  logic             sel_col;

  // One popcount per row and per column; the map is stable once collection ends
  genvar g, h;
  generate
    for (g = 0; g < N; g++) begin : g_cnt
      logic [CNT_WIDTH-1:0] row_cnt;
      logic [CNT_WIDTH-1:0] col_cnt;
      for (h = 0; h < N; h++) begin : g_col
        assign col_bits[g][h] = map[h][g];
      end
      fault_popcount #(.WIDTH(N), .CNT_WIDTH(CNT_WIDTH)) u_row_cnt (
        .bits  (map[g]),
        .count (row_cnt)
      );
      fault_popcount #(.WIDTH(N), .CNT_WIDTH(CNT_WIDTH)) u_col_cnt (
        .bits  (col_bits[g]),
        .count (col_cnt)
      );
      assign row_flag_nx[g] = (row_cnt >= CNT_WIDTH'(ROW_THRESHOLD));
      assign col_flag_nx[g] = (col_cnt >= CNT_WIDTH'(COL_THRESHOLD));
    end
  endgenerate

  // Out-of-range rows are dropped, so the truncated index is only used when in range
  assign wr_idx   = pe_fault_row[IDX_W-1:0];
  assign wr_ok    = pe_fault_valid && (32'(pe_fault_row) < N);
  assign cur_idx  = counter[IDX_W-1:0];
  assign nxt_idx  = cur_idx + IDX_W'(1);
  assign last_row = (32'(counter) == N - 1);

  // Row presented on the next edge: row 0 with fresh flags leaving ANALYZE, else the following row
  always_comb begin
    sel_idx       = (state == FA_ANALYZE) ? '0 : nxt_idx;
    sel_row_flags = (state == FA_ANALYZE) ? row_flag_nx : row_flag;
    sel_col_flags = (state == FA_ANALYZE) ? col_flag_nx : col_flag;
    sel_row       = sel_row_flags[sel_idx];
    sel_col       = sel_col_flags[sel_idx];
`ifdef FAULT_ANALYZER_MASK_EN
    sel_single    = map[sel_idx] & ~{N{sel_row}} & ~sel_col_flags;
`else
    sel_single    = map[sel_idx];
`endif
  end

  // Controller, fault map and registered eNVM write outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= FA_IDLE;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      detection_en           <= 1'b0;
      counter                <= '0;
      single_pe_detection    <= '0;
      row_fault_detection    <= 1'b0;
      column_fault_detection <= 1'b0;
      row_flag               <= '0;
      col_flag               <= '0;
      for (int r = 0; r < N; r++) map[r] <= '0;
    end else begin
      case (state)
        FA_IDLE: begin
          counter      <= '0;
          done         <= 1'b0;
          detection_en <= 1'b0;
          if (start) begin
            for (int r = 0; r < N; r++) map[r] <= '0;
            busy  <= 1'b1;
            state <= FA_COLLECT;
          end
        end
        FA_COLLECT: begin
          if (wr_ok) map[wr_idx] <= map[wr_idx] | pe_fault_vec;
          if (test_done) state <= FA_ANALYZE;
        end
        FA_ANALYZE: begin
          row_flag               <= row_flag_nx;
          col_flag               <= col_flag_nx;
          detection_en           <= 1'b1;
          counter                <= '0;
          single_pe_detection    <= sel_single;
          row_fault_detection    <= sel_row;
          column_fault_detection <= sel_col;
          state                  <= FA_DUMP;
        end
        FA_DUMP: begin
          if (last_row) begin
            detection_en           <= 1'b0;
            single_pe_detection    <= '0;
            row_fault_detection    <= 1'b0;
            column_fault_detection <= 1'b0;
            done                   <= 1'b1;
            state                  <= FA_DONE;
          end else begin
            counter                <= counter + ADDR_WIDTH'(1);
            single_pe_detection    <= sel_single;
            row_fault_detection    <= sel_row;
            column_fault_detection <= sel_col;
          end
        end
        FA_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          counter <= '0;
          state   <= FA_IDLE;
        end
        default: state <= FA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_analyzer.sv
// tb/tb_fault_analyzer.sv - scoreboard bench for fault_analyzer with a map-level reference model
module tb_fault_analyzer;

  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pe_fault_valid;
  logic [AW-1:0] pe_fault_row;
  logic [N-1:0]  pe_fault_vec;
  logic          test_done;
  logic          busy;
  logic          done;
  logic          detection_en;
  logic [AW-1:0] counter;
  logic [N-1:0]  single_pe_detection;
  logic          row_fault_detection;
  logic          column_fault_detection;

  fault_analyzer #(.SYSTOLIC_SIZE(N), .ADDR_WIDTH(AW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .pe_fault_valid         (pe_fault_valid),
    .pe_fault_row           (pe_fault_row),
    .pe_fault_vec           (pe_fault_vec),
    .test_done              (test_done),
    .busy                   (busy),
    .done                   (done),
    .detection_en           (detection_en),
    .counter                (counter),
    .single_pe_detection    (single_pe_detection),
    .row_fault_detection    (row_fault_detection),
    .column_fault_detection (column_fault_detection)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         idx;
    logic [7:0] single;
    logic       rf;
    logic       cf;
  } strobe_t;

  strobe_t    exp_q[$];
  int         done_q[$];
  int         exp_done;
  logic [7:0] ref_map [N];
  int         errors = 0;
  int         checks = 0;
  strobe_t    mon_e;
  int         mon_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected eNVM stream from the sticky map: thresholds applied to plain bit counts
  task automatic push_expect(input int c, input int nrows);
    logic [7:0] colv;
    logic [7:0] rowmask;
    strobe_t    e;
    int         cnt;
    for (int cc = 0; cc < N; cc++) begin
      cnt = 0;
      for (int r = 0; r < N; r++) cnt += int'(ref_map[r][cc]);
      colv[cc] = (cnt >= 2);
    end
    for (int r = 0; r < nrows; r++) begin
      e.at  = c + 2 + r;
      e.idx = r;
      e.rf  = ($countones(ref_map[r]) >= 2);
      e.cf  = colv[r];
      rowmask = e.rf ? 8'hff : 8'h00;
`ifdef FAULT_ANALYZER_MASK_EN
      e.single = ref_map[r] & ~rowmask & ~colv;
`else
      e.single = ref_map[r] | (rowmask & 8'h00);
`endif
      exp_q.push_back(e);
    end
    if (nrows == N) begin
      exp_done = c + N + 2;
      done_q.push_back(exp_done);
    end
  endtask

  // Monitor: every strobe and every done pulse must match the head of its queue
  always @(negedge clk) begin
    if (detection_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got counter %0d expected no strobe (cycle %0d)", counter, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_cycle", cyc, mon_e.at);
        chk("counter", counter, mon_e.idx);
        chk("single_pe", single_pe_detection, mon_e.single);
        chk("row_fault", row_fault_detection, mon_e.rf);
        chk("col_fault", column_fault_detection, mon_e.cf);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        mon_d = done_q.pop_front();
        chk("done_cycle", cyc, mon_d);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    rst            = 1'b0;
    start          = 1'b0;
    pe_fault_valid = 1'b0;
    test_done      = 1'b0;
    pe_fault_row   = '0;
    pe_fault_vec   = '0;
  endtask

  task automatic begin_session();
    step();
    start = 1'b1;
    for (int r = 0; r < N; r++) ref_map[r] = 8'h00;
    step();
    chk("busy_after_start", busy, 1);
  endtask

  task automatic report(input int row, input logic [7:0] vec, input bit last);
    step();
    pe_fault_valid = 1'b1;
    pe_fault_row   = AW'(row);
    pe_fault_vec   = vec;
    test_done      = last;
    if (row < N) ref_map[row] = ref_map[row] | vec;
    if (last) push_expect(cyc, N);
  endtask

  task automatic send_done();
    step();
    test_done = 1'b1;
    push_expect(cyc, N);
  endtask

  task automatic finish_session();
    for (int k = 0; k < 40 && cyc < exp_done + 1; k++) step();
    chk("busy_after_done", busy, 0);
    chk("strobes_left", exp_q.size(), 0);
    chk("done_left", done_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int c0;
    int n;
    bit sent;
    rst = 1'b1; start = 1'b0; pe_fault_valid = 1'b0; test_done = 1'b0;
    pe_fault_row = '0; pe_fault_vec = '0;
    step(); rst = 1'b1;
    step(); rst = 1'b1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_det_en", detection_en, 0);
    chk("rst_counter", counter, 0);
    chk("rst_single", single_pe_detection, 0);
    chk("rst_row", row_fault_detection, 0);
    chk("rst_col", column_fault_detection, 0);

    // No faults
    begin_session();
    send_done();
    finish_session();

    // Reports and test_done while idle are ignored
    step(); pe_fault_valid = 1'b1; pe_fault_row = 4'd1; pe_fault_vec = 8'hff; test_done = 1'b1;
    step();
    step();

    // Single fault
    begin_session();
    report(3, 8'h20, 0);
    send_done();
    finish_session();

    // Row fault
    begin_session();
    report(2, 8'h03, 1);
    finish_session();

    // Column fault
    begin_session();
    report(1, 8'h10, 0);
    step();
    report(6, 8'h10, 0);
    send_done();
    finish_session();

    // Sticky merge, out-of-range row, report merged with test_done
    begin_session();
    report(0, 8'h01, 0);
    report(9, 8'hff, 0);
    step();
    report(0, 8'h80, 1);
    finish_session();

    // start and reports during DUMP are ignored
    begin_session();
    report(5, 8'h22, 0);
    report(1, 8'h02, 1);
    for (int k = 0; k < 20 && cyc < exp_done - 6; k++) step();
    start = 1'b1; pe_fault_valid = 1'b1; pe_fault_row = 4'd0; pe_fault_vec = 8'hff; test_done = 1'b1;
    finish_session();
    step();
    chk("busy_after_ignored_start", busy, 0);

    // Reset in the middle of DUMP abandons the stream
    begin_session();
    report(2, 8'h03, 0);
    report(5, 8'h40, 0);
    step();
    test_done = 1'b1;
    c0 = cyc;
    push_expect(c0, 5);
    for (int k = 0; k < 20 && cyc < c0 + 6; k++) step();
    chk("counter_before_rst", counter, 4);
    rst = 1'b1;
    step();
    chk("rst_mid_det_en", detection_en, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_counter", counter, 0);
    for (int k = 0; k < 6; k++) step();
    chk("rst_mid_strobes_left", exp_q.size(), 0);

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      begin_session();
      n = $urandom_range(0, 7);
      sent = 1'b0;
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) step();
        sent = (k == n - 1) && ($urandom_range(0, 1) == 1);
        report($urandom_range(0, 15), 8'($urandom & $urandom & $urandom), sent);
      end
      if (!sent) send_done();
      finish_session();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
